char_line_renderer: RTL and testbench
=====================================

Name: char_line_renderer

Overview:
- Pixel-mask renderer for a horizontal line of NUM_CHARS bar-drawn glyphs (score digits, "P1", "-" and similar) on the pong VGA screen.
- Takes the scan position x/y and produces a registered per-pixel `display` flag, 2 clocks later, for the colour mux.
- Text, position and 1x/2x scale are updated through a valid/ready load port. Updates are double-buffered and take effect only at frame start, so there is no tearing.

Parameters:
- NUM_CHARS, 4, number of glyph cells in the line (1..8)
- GAP, 4, unscaled blank columns between adjacent cells
- COORD_W, 10, width of x/y and position coordinates
- BLINK_FRAMES, 30, frames per blink half-period (used only with CHAR_BLINK_EN)

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse at the start of each frame
- pix_valid  in  1  x/y are inside the visible area
- x  in  COORD_W  scan column
- y  in  COORD_W  scan row
- load_valid  in  1  update request
- load_ready  out  1  update can be accepted
- load_text  in  4*NUM_CHARS  glyph codes; char k = bits [4k+3:4k], char 0 is leftmost
- load_x  in  COORD_W  left edge of char 0
- load_y  in  COORD_W  top edge
- load_scale  in  1  0 = 1x, 1 = 2x
- load_blink  in  NUM_CHARS  per-char blink mask (present only with CHAR_BLINK_EN)
- display  out  1  pixel is lit (registered)

Behaviour:
- Reset (reset_n=0 at clk edge):
  - active text = all 4'hF (blank); pos = 0,0; scale = 0
  - pending = 0; load_ready = 1; display = 0; pipeline regs cleared
  - reset has priority over all other inputs
- Glyph cell (unscaled): 26 wide x 40 high, local coords lx, ly. Segments are half-open ranges:
  - a: lx[5,21) ly[0,5)
  - b: lx[16,21) ly[0,23)
  - c: lx[16,21) ly[18,40)
  - d: lx[5,21) ly[35,40)
  - e: lx[5,10) ly[18,40)
  - f: lx[5,10) ly[0,23)
  - g: lx[5,21) ly[18,23)
  - h: lx[10,16) ly[5,35)
- Glyph codes:
  - 0..9 = standard seven-segment digits using a..g (1 = b,c; 7 = a,b,c)
  - 10 = 'I' (a,d,h)
  - 11 = 'P' (a,b,e,f,g)
  - 12 = '-' (g)
  - 13..15 = blank
- Geometry, s = scale:
  - pitch = (26+GAP)<<s
  - dx = x - pos_x and dy = y - pos_y, computed COORD_W+1 bits wide; a negative result is outside
  - char k is hit when dx is in [k*pitch, k*pitch + (26<<s)) and dy is in [0, 40<<s), for k < NUM_CHARS
  - lx = (dx - k*pitch)>>s; ly = dy>>s
  - gap columns, out-of-line pixels and pix_valid=0 are unlit
  - no horizontal or vertical wrap: cells extending past the coordinate max are clipped
- Pipeline: stage 1 registers hit, k, lx, ly; stage 2 registers the segment lookup into `display`.
  - Latency is exactly 2 clocks from x/y/pix_valid; throughput is 1 pixel per clock.
- Load handshake:
  - A transfer occurs when load_valid && load_ready. Payload is copied to the shadow regs; pending = 1; load_ready = 0 from the next cycle.
  - On frame_start with pending=1: shadow is copied to active; pending = 0; load_ready = 1 next cycle.
  - A transfer in the same cycle as frame_start is held pending until the NEXT frame_start. It is never committed in the cycle it is accepted.
  - load_ready does not depend on load_valid (no combinational path).
- Active set changes only at commit. Pixels already in the pipeline finish with the values they entered with.

Optional Feature:
- Macro: CHAR_BLINK_EN
- Defined:
  - adds the load_blink port, shadowed and committed like the text
  - a frame counter (0..BLINK_FRAMES-1, incremented on frame_start) toggles a phase bit on wrap
  - while phase=1, chars whose blink bit is 1 render unlit
  - reset clears the counter, phase and mask
- Not defined: no port, no counter, all chars always visible.

Test Plan:
- Reset then scan full frame -> display=0 everywhere; load_ready=1.
- Load text {F,F,F,10}, pos (100,50), scale 0; frame_start; scan -> (105,50) lit, (110,55) lit, (104,50) unlit, (126,50) unlit, (106,90) unlit; each lit pixel appears 2 clocks after its x/y.
- Load digits "1","2", scale 1, GAP 4, pos (0,0) -> char 1 starts at x=60; (92,0) lit (digit 2 segment b); (52,0) unlit (gap); y=80 unlit.
- Load accepted, second load_valid held high -> load_ready=0 until frame_start, then second load accepted on the cycle after ready rises; display unchanged until commit.
- load_valid coincident with frame_start -> old image for that frame, new image after the following frame_start.
- CHAR_BLINK_EN, BLINK_FRAMES=2, blink mask 0001 -> char 0 lit on frames 0-1, unlit on frames 2-3, others always lit; reset_n=0 mid-frame -> display=0 next cycle, counter=0.

Source files
------------

// File: rtl/char_line_renderer.sv
// char_line_renderer: pixel mask for a horizontal line of bar-drawn glyphs.
// Two-stage pipeline: stage 1 resolves which cell the scan position falls
// in plus its local coordinates, and stage 2 looks up the segments into
// `display`. Text, position and scale are double-buffered. A new value is
// accepted through the load port and committed at the next frame_start.
// Optional feature macro: CHAR_BLINK_EN. It adds a per-char blink mask and
// a frame counter that hides the masked chars every other blink period.
module char_line_renderer #(
  parameter int NUM_CHARS    = 4,
  parameter int GAP          = 4,
  parameter int COORD_W      = 10,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_start,
  input  logic                   pix_valid,
  input  logic [COORD_W-1:0]     x,
  input  logic [COORD_W-1:0]     y,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [4*NUM_CHARS-1:0] load_text,
  input  logic [COORD_W-1:0]     load_x,
  input  logic [COORD_W-1:0]     load_y,
  input  logic                   load_scale,
`ifdef CHAR_BLINK_EN
  input  logic [NUM_CHARS-1:0]   load_blink,
`endif
  output logic                   display
);

  localparam int CELL_W = 26;
  localparam int CELL_H = 40;
  localparam int PITCH1 = CELL_W + GAP;

  // Active (displayed) and shadow (pending) configuration
  logic [4*NUM_CHARS-1:0] text_reg, text_shadow_reg;
  logic [COORD_W-1:0]     pos_x_reg, pos_y_reg, pos_x_shadow_reg, pos_y_shadow_reg;
  logic                   scale_reg, scale_shadow_reg;
  logic                   pending_reg;

  // Ready is purely a function of state, never of load_valid
  assign load_ready = !pending_reg;

  // Load handshake and frame-start commit. A commit needs pending=1 and an
  // accept needs pending=0, so a load that lands on a frame_start waits for
  // the following frame_start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      text_reg         <= '1;
      pos_x_reg        <= '0;
      pos_y_reg        <= '0;
      scale_reg        <= 1'b0;
      text_shadow_reg  <= '1;
      pos_x_shadow_reg <= '0;
      pos_y_shadow_reg <= '0;
      scale_shadow_reg <= 1'b0;
      pending_reg      <= 1'b0;
    end else if (frame_start && pending_reg) begin
      text_reg    <= text_shadow_reg;
      pos_x_reg   <= pos_x_shadow_reg;
      pos_y_reg   <= pos_y_shadow_reg;
      scale_reg   <= scale_shadow_reg;
      pending_reg <= 1'b0;
    end else if (load_valid && !pending_reg) begin
      text_shadow_reg  <= load_text;
      pos_x_shadow_reg <= load_x;
      pos_y_shadow_reg <= load_y;
      scale_shadow_reg <= load_scale;
      pending_reg      <= 1'b1;
    end
  end

`ifdef CHAR_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [NUM_CHARS-1:0] blink_reg, blink_shadow_reg;
  logic [BW-1:0]        frame_cnt_reg;
  logic                 phase_reg;

  // Blink mask shadowing plus the frame counter that flips the phase on wrap
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_reg        <= '0;
      blink_shadow_reg <= '0;
      frame_cnt_reg    <= '0;
      phase_reg        <= 1'b0;
    end else begin
      if (frame_start && pending_reg) begin
        blink_reg <= blink_shadow_reg;
      end else if (load_valid && !pending_reg) begin
        blink_shadow_reg <= load_blink;
      end
      if (frame_start) begin
        if (frame_cnt_reg == BW'(BLINK_FRAMES - 1)) begin
          frame_cnt_reg <= '0;
          phase_reg     <= !phase_reg;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
      end
    end
  end
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^32'(BLINK_FRAMES);
`endif

  // Stage 1 geometry. The subtractions carry one extra bit so that a scan
  // position left of / above the line shows up as a set MSB.
  logic [COORD_W:0]     dx, dy;
  logic [31:0]          dx_u, dy_u, pitch, cell_w, cell_h;
  logic [31:0]          cell_start [NUM_CHARS];
  logic [NUM_CHARS-1:0] col_hit;
  logic                 row_hit;

  assign dx      = {1'b0, x} - {1'b0, pos_x_reg};
  assign dy      = {1'b0, y} - {1'b0, pos_y_reg};
  assign dx_u    = 32'(dx[COORD_W-1:0]);
  assign dy_u    = 32'(dy[COORD_W-1:0]);
  assign pitch   = scale_reg ? 32'(2 * PITCH1) : 32'(PITCH1);
  assign cell_w  = scale_reg ? 32'(2 * CELL_W) : 32'(CELL_W);
  assign cell_h  = scale_reg ? 32'(2 * CELL_H) : 32'(CELL_H);
  assign row_hit = !dy[COORD_W] && (dy_u < cell_h);

  for (genvar gi = 0; gi < NUM_CHARS; gi++) begin : g_cell
    assign cell_start[gi] = pitch * 32'(gi);
    assign col_hit[gi]    = !dx[COORD_W] && (dx_u >= cell_start[gi]) &&
                            (dx_u < cell_start[gi] + cell_w);
  end

  logic [3:0] sel_code;
  logic [6:0] sel_off;
  logic       sel_hidden;

  // Pick the glyph code and column offset of the cell under the scan
  // position; cells never overlap, so at most one col_hit bit is set.
  always_comb begin
    sel_code   = 4'hF;
    sel_off    = '0;
    sel_hidden = 1'b0;
    for (int k = 0; k < NUM_CHARS; k++) begin
      if (col_hit[k]) begin
        sel_code = text_reg[4*k +: 4];
        sel_off  = 7'(dx_u - cell_start[k]);
`ifdef CHAR_BLINK_EN
        sel_hidden = phase_reg && blink_reg[k];
`endif
      end
    end
  end

  logic       s1_hit_reg;
  logic [3:0] s1_code_reg;
  logic [5:0] s1_lx_reg, s1_ly_reg;

  // Stage 1 register: hit flag, glyph code and unscaled local coordinates
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_hit_reg  <= 1'b0;
      s1_code_reg <= 4'hF;
      s1_lx_reg   <= '0;
      s1_ly_reg   <= '0;
    end else begin
      s1_hit_reg  <= pix_valid && row_hit && (|col_hit) && !sel_hidden;
      s1_code_reg <= sel_code;
      s1_lx_reg   <= scale_reg ? sel_off[6:1] : sel_off[5:0];
      s1_ly_reg   <= scale_reg ? dy[6:1] : dy[5:0];
    end
  end

  // Segment geometry (bit 0 = a ... bit 7 = h) and per-code segment masks
  logic [7:0] seg_on, seg_mask;
  always_comb begin
    seg_on[0] = (s1_lx_reg >= 6'd5)  && (s1_lx_reg < 6'd21) && (s1_ly_reg < 6'd5);
    seg_on[1] = (s1_lx_reg >= 6'd16) && (s1_lx_reg < 6'd21) && (s1_ly_reg < 6'd23);
    seg_on[2] = (s1_lx_reg >= 6'd16) && (s1_lx_reg < 6'd21) &&
                (s1_ly_reg >= 6'd18) && (s1_ly_reg < 6'd40);
    seg_on[3] = (s1_lx_reg >= 6'd5)  && (s1_lx_reg < 6'd21) &&
                (s1_ly_reg >= 6'd35) && (s1_ly_reg < 6'd40);
    seg_on[4] = (s1_lx_reg >= 6'd5)  && (s1_lx_reg < 6'd10) &&
                (s1_ly_reg >= 6'd18) && (s1_ly_reg < 6'd40);
    seg_on[5] = (s1_lx_reg >= 6'd5)  && (s1_lx_reg < 6'd10) && (s1_ly_reg < 6'd23);
    seg_on[6] = (s1_lx_reg >= 6'd5)  && (s1_lx_reg < 6'd21) &&
                (s1_ly_reg >= 6'd18) && (s1_ly_reg < 6'd23);
    seg_on[7] = (s1_lx_reg >= 6'd10) && (s1_lx_reg < 6'd16) &&
                (s1_ly_reg >= 6'd5)  && (s1_ly_reg < 6'd35);
    case (s1_code_reg)
      4'd0:    seg_mask = 8'h3F;
      4'd1:    seg_mask = 8'h06;
      4'd2:    seg_mask = 8'h5B;
      4'd3:    seg_mask = 8'h4F;
      4'd4:    seg_mask = 8'h66;
      4'd5:    seg_mask = 8'h6D;
      4'd6:    seg_mask = 8'h7D;
      4'd7:    seg_mask = 8'h07;
      4'd8:    seg_mask = 8'h7F;
      4'd9:    seg_mask = 8'h6F;
      4'd10:   seg_mask = 8'h89;  // I: a, d, h
      4'd11:   seg_mask = 8'h73;  // P: a, b, e, f, g
      4'd12:   seg_mask = 8'h40;  // -: g
      default: seg_mask = 8'h00;
    endcase
  end

  logic display_reg;
  assign display = display_reg;

  // Stage 2 register: final lit flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      display_reg <= 1'b0;
    end else begin
      display_reg <= s1_hit_reg && (|(seg_on & seg_mask));
    end
  end

endmodule

// File: tb/tb_char_line_renderer.sv
// Directed testbench for char_line_renderer: reset, glyph geometry at 1x and
// 2x, latency/throughput, load handshake and frame-start commit timing.
// Covers the CHAR_BLINK_EN feature when that macro is defined.
module tb_char_line_renderer;
  logic        clk = 1'b0;
  logic        reset_n, frame_start, pix_valid, load_valid, load_ready;
  logic        load_scale, display;
  logic [9:0]  x, y, load_x, load_y;
  logic [15:0] load_text;
`ifdef CHAR_BLINK_EN
  logic [3:0]  load_blink;
`endif
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  char_line_renderer #(
    .NUM_CHARS(4), .GAP(4), .COORD_W(10), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .pix_valid(pix_valid), .x(x), .y(y),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_text(load_text), .load_x(load_x), .load_y(load_y),
    .load_scale(load_scale),
`ifdef CHAR_BLINK_EN
    .load_blink(load_blink),
`endif
    .display(display)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("pass %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Present one pixel and check display two clocks later
  task automatic probe(input string tag, input logic [9:0] px, input logic [9:0] py, input logic exp);
    pix_valid = 1'b1;
    x = px;
    y = py;
    step();
    step();
    check(tag, display, exp);
    pix_valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int c = 0; c < 20 && !load_ready; c++) step();
    check("ready_wait", load_ready, 1);
  endtask

  task automatic do_load(input logic [15:0] t, input logic [9:0] lx, input logic [9:0] ly, input logic sc);
    wait_ready();
    load_valid = 1'b1;
    load_text  = t;
    load_x     = lx;
    load_y     = ly;
    load_scale = sc;
    step();
    load_valid = 1'b0;
    $display("load text=%h pos=(%0d,%0d) scale=%0d", t, lx, ly, sc);
  endtask

  // Stream for the throughput check: image "I" at (100,50), 1x
  logic [9:0] sx [6] = '{10'd105, 10'd104, 10'd110, 10'd126, 10'd106, 10'd115};
  logic [9:0] sy [6] = '{10'd50,  10'd50,  10'd55,  10'd50,  10'd90,  10'd80};
  logic       se [6] = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b0,    1'b1};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic lit;
    reset_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; load_valid = 1'b0;
    x = '0; y = '0; load_text = '1; load_x = '0; load_y = '0; load_scale = 1'b0;
`ifdef CHAR_BLINK_EN
    load_blink = '0;
`endif
    step(); step(); step();
    reset_n = 1'b1;
    check("rst_ready", load_ready, 1);
    check("rst_display", display, 0);

    // Coarse scan of the visible area: nothing may light after reset
    lit = 1'b0;
    for (int yy = 0; yy < 480; yy += 8) begin
      for (int xx = 0; xx < 640; xx += 4) begin
        pix_valid = 1'b1; x = 10'(xx); y = 10'(yy);
        step();
        lit |= display;
      end
    end
    pix_valid = 1'b0;
    step(); lit |= display;
    step(); lit |= display;
    check("rst_scan", lit, 0);

    // 'I' at (100,50), 1x
    do_load(16'hFFFA, 10'd100, 10'd50, 1'b0);
    check("load_ready_low", load_ready, 0);
    probe("pre_commit", 10'd105, 10'd50, 0);
    frame();
    check("commit_ready", load_ready, 1);
    probe("i_seg_a", 10'd105, 10'd50, 1);
    probe("i_seg_h", 10'd110, 10'd55, 1);
    probe("i_left_edge", 10'd104, 10'd50, 0);
    probe("i_gap", 10'd126, 10'd50, 0);
    probe("i_below", 10'd106, 10'd90, 0);

    // Latency: lit pixel is not visible after one clock, visible after two
    step(); step();
    pix_valid = 1'b1; x = 10'd105; y = 10'd50;
    step();
    check("lat_1clk", display, 0);
    step();
    check("lat_2clk", display, 1);
    pix_valid = 1'b0;
    step(); step();

    // Throughput: one pixel per clock, display trails x/y by two clocks
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        pix_valid = 1'b1; x = sx[i]; y = sy[i];
      end else begin
        pix_valid = 1'b0;
      end
      step();
      if (i >= 1) check($sformatf("stream_%0d", i - 1), display, se[i-1]);
    end
    step();

    // "12" at (0,0), 2x: pitch 60
    do_load(16'hFF21, 10'd0, 10'd0, 1'b1);
    frame();
    probe("x2_c1_seg_b", 10'd92, 10'd0, 1);
    probe("x2_gap", 10'd52, 10'd0, 0);
    probe("x2_below", 10'd92, 10'd80, 0);
    probe("x2_c0_seg_b", 10'd34, 10'd0, 1);
    probe("x2_c0_no_a", 10'd10, 10'd0, 0);
    probe("x2_c0_dx_neg", 10'd1023, 10'd0, 0);

    // Held load_valid: A accepted, B waits for ready after commit
    wait_ready();
    load_valid = 1'b1; load_text = 16'hFFFB; load_x = 10'd200; load_y = 10'd100; load_scale = 1'b0;
    step();
    check("hold_ready0", load_ready, 0);
    load_text = 16'hFFFC;
    step(); step(); step();
    check("hold_ready0_late", load_ready, 0);
    probe("hold_old_lit", 10'd92, 10'd0, 1);
    probe("hold_new_unlit", 10'd205, 10'd100, 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("hold_commit_ready1", load_ready, 1);
    step();
    check("hold_second_accept", load_ready, 0);
    load_valid = 1'b0;
    probe("imgA_seg_a", 10'd205, 10'd100, 1);
    probe("imgA_no_c", 10'd217, 10'd130, 0);
    frame();
    probe("imgB_no_a", 10'd205, 10'd100, 0);
    probe("imgB_seg_g", 10'd210, 10'd120, 1);

    // Load coincident with frame_start: committed one frame later
    wait_ready();
    load_valid = 1'b1; load_text = 16'hFFF8; load_x = 10'd200; load_y = 10'd100; load_scale = 1'b0;
    frame_start = 1'b1;
    step();
    load_valid = 1'b0; frame_start = 1'b0;
    check("coinc_ready0", load_ready, 0);
    probe("coinc_old", 10'd205, 10'd100, 0);
    frame();
    probe("coinc_new", 10'd205, 10'd100, 1);

    // Reset mid-frame
    pix_valid = 1'b1; x = 10'd205; y = 10'd100;
    step(); step();
    check("pre_rst_lit", display, 1);
    reset_n = 1'b0;
    step();
    check("rst_mid_display", display, 0);
    check("rst_mid_ready", load_ready, 1);
    reset_n = 1'b1;
    pix_valid = 1'b0;
    probe("rst_blank", 10'd205, 10'd100, 0);

`ifdef CHAR_BLINK_EN
    // Blink char 0 with a two-frame half-period
    load_blink = 4'b0001;
    do_load(16'h8888, 10'd0, 10'd0, 1'b0);
    frame();
    probe("blink_ph0_c0", 10'd5, 10'd0, 1);
    probe("blink_ph0_c1", 10'd35, 10'd0, 1);
    frame();
    probe("blink_ph1_c0", 10'd5, 10'd0, 0);
    probe("blink_ph1_c1", 10'd35, 10'd0, 1);
    frame();
    probe("blink_ph1b_c0", 10'd5, 10'd0, 0);
    frame();
    probe("blink_ph0b_c0", 10'd5, 10'd0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
